// File: rtl/secded_pkg.sv
// secded_pkg: shared definitions for the SECDED codec.
//   - calc_r       : number of Hamming check bits for a given data width
//   - status / op encodings
//   - data-position mapping (place_data / extract_data)
//   - hamming_xor  : per-check-bit XOR over all Hamming positions; it yields
//                    the check bits for an encode and the syndrome for a decode
//   - encode       : full SECDED encode (check bits + overall parity in bit 0)
// The functions work on MAX_CW-wide vectors. Callers zero-extend their operands
// and slice the result down to their own width.
package secded_pkg;

   localparam int MAX_R  = 7;
   localparam int MAX_CW = 128;

   localparam logic [1:0] ST_CLEAN  = 2'b00;
   localparam logic [1:0] ST_CORR   = 2'b01;
   localparam logic [1:0] ST_UNCORR = 2'b10;

   localparam logic OP_ENC = 1'b0;
   localparam logic OP_DEC = 1'b1;

   // Smallest r with 2^r >= dw + r + 1.
   function automatic int calc_r(input int dw);
      int r;
      r = MAX_R;
      for (int i = MAX_R; i >= 1; i--) begin
         if ((1 << i) >= dw + i + 1) r = i;
      end
      return r;
   endfunction

   function automatic logic is_pow2(input int p);
      return (p > 0) && ((p & (p - 1)) == 0);
   endfunction

   // Data bits fill the non-power-of-two positions LSB-first (d0 at position 3).
   function automatic logic [MAX_CW-1:0] place_data(input logic [MAX_CW-1:0] data, input int dw);
      logic [MAX_CW-1:0] cw;
      int idx;
      cw  = '0;
      idx = 0;
      for (int p = 1; p < MAX_CW; p++) begin
         if (!is_pow2(p)) begin
            if (idx < dw) cw[p] = data[idx];
            idx++;
         end
      end
      return cw;
   endfunction

   function automatic logic [MAX_CW-1:0] extract_data(input logic [MAX_CW-1:0] cw, input int dw);
      logic [MAX_CW-1:0] data;
      int idx;
      data = '0;
      idx  = 0;
      for (int p = 1; p < MAX_CW; p++) begin
         if (!is_pow2(p)) begin
            if (idx < dw) data[idx] = cw[p];
            idx++;
         end
      end
      return data;
   endfunction

   // Bit k of the result is the XOR of every position 1..n whose index has bit k set.
   function automatic logic [MAX_R-1:0] hamming_xor(input logic [MAX_CW-1:0] cw, input int n);
      logic [MAX_R-1:0] s;
      s = '0;
      for (int p = 1; p < MAX_CW; p++) begin
         if (p <= n) begin
            for (int k = 0; k < MAX_R; k++) begin
               if (p[k]) s[k] = s[k] ^ cw[p];
            end
         end
      end
      return s;
   endfunction

   function automatic logic [MAX_CW-1:0] encode(input logic [MAX_CW-1:0] data, input int dw);
      logic [MAX_CW-1:0] cw;
      logic [MAX_R-1:0]  chk;
      int r;
      r   = calc_r(dw);
      cw  = place_data(data, dw);
      // Check positions are still zero here, so the XOR is just the data contribution.
      chk = hamming_xor(cw, dw + r);
      for (int k = 0; k < MAX_R; k++) begin
         if (k < r) cw[1 << k] = chk[k];
      end
      cw[0] = ^cw;
      return cw;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// secded_syndrome: combinational syndrome / overall-parity generator.
//   cw_i  [CW_W-1:0] : received codeword (bit 0 overall parity, [N:1] Hamming positions)
//   syn_o [R-1:0]    : recomputed check bits XOR received check bits
//   par_o            : XOR of all CW_W received bits (1 = odd number of flips)
module secded_syndrome
   import secded_pkg::*;
#(
   parameter  int DATA_W = 8,
   localparam int R      = calc_r(DATA_W),
   localparam int N      = DATA_W + R,
   localparam int CW_W   = N + 1
) (
   input  logic [CW_W-1:0] cw_i,
   output logic [R-1:0]    syn_o,
   output logic            par_o
);

   logic [MAX_CW-1:0] cw_ext_s;
   logic [MAX_R-1:0]  syn_full_s;
   logic              unused_s;

   // XOR over all positions including the check bits gives recomputed ^ received.
   always_comb begin
      cw_ext_s             = '0;
      cw_ext_s[CW_W-1:0]   = cw_i;
      syn_full_s           = hamming_xor(cw_ext_s, N);
   end

   assign syn_o    = syn_full_s[R-1:0];
   assign par_o    = ^cw_i;
   assign unused_s = ^syn_full_s;

endmodule

// File: rtl/secded_codec_pipe.sv
// secded_codec_pipe: 2-stage pipelined SECDED encoder/decoder with valid/ready.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready       : input handshake (in_ready = !out_valid || out_ready)
//   in_op                   : 0 encode, 1 decode
//   in_data / in_cw         : data to encode / codeword to decode
//   inj_mask                : XORed onto the encoded codeword (test injection)
//   out_valid/out_ready     : output handshake
//   out_op, out_data, out_cw: result op, data, codeword
//   out_status, out_syn     : 00 clean / 01 corrected / 10 uncorrectable, {parity, syndrome}
//   cnt_clr, ce_cnt, ue_cnt : saturating corrected / uncorrectable counters
// S1 registers the input plus the decode syndrome; S2 registers the result.
// Both stages advance together on a global stall, so out_* hold while stalled.
module secded_codec_pipe
   import secded_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int CNT_W  = 16,
   localparam int R      = calc_r(DATA_W),
   localparam int N      = DATA_W + R,
   localparam int CW_W   = N + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_op,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CW_W-1:0]   in_cw,
   input  logic [CW_W-1:0]   inj_mask,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_op,
   output logic [DATA_W-1:0] out_data,
   output logic [CW_W-1:0]   out_cw,
   output logic [1:0]        out_status,
   output logic [R:0]        out_syn,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  ce_cnt,
   output logic [CNT_W-1:0]  ue_cnt
);

   localparam logic [R-1:0]     N_R     = R'(N);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic adv_s;

   // Stage 1 registers
   logic              v1_q;
   logic              op1_q;
   logic [DATA_W-1:0] data1_q;
   logic [CW_W-1:0]   cw1_q;
   logic [CW_W-1:0]   mask1_q;
   logic [R-1:0]      syn1_q;
   logic              par1_q;

   // Stage 2 (output) registers and their next-state values
   logic              out_valid_q;
   logic              out_op_q;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CW_W-1:0]   out_cw_q, out_cw_d;
   logic [1:0]        out_status_q, out_status_d;
   logic [R:0]        out_syn_q, out_syn_d;

   logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d;
   logic [CNT_W-1:0]  ue_cnt_q, ue_cnt_d;

   logic [R-1:0]      syn_s;
   logic              par_s;
   logic [MAX_CW-1:0] data_ext_s, enc_full_s, dec_ext_s, dec_full_s;
   logic [CW_W-1:0]   flip_s;
   logic              unused_s;

   assign adv_s    = !out_valid_q || out_ready;
   assign in_ready = adv_s;

   secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
      .cw_i  (in_cw),
      .syn_o (syn_s),
      .par_o (par_s)
   );

   // S2 result: encode with injection, or decode classification and correction.
   always_comb begin
      data_ext_s               = '0;
      data_ext_s[DATA_W-1:0]   = data1_q;
      enc_full_s               = encode(data_ext_s, DATA_W);
      flip_s                   = '0;
      dec_ext_s                = '0;
      dec_full_s               = '0;
      out_status_d             = ST_CLEAN;
      out_syn_d                = '0;
      out_cw_d                 = enc_full_s[CW_W-1:0] ^ mask1_q;
      out_data_d               = data1_q;
      if (op1_q == OP_DEC) begin
         out_syn_d = {par1_q, syn1_q};
         if (!par1_q && (syn1_q == '0)) begin
            out_status_d = ST_CLEAN;
         end else if (par1_q && (syn1_q == '0)) begin
            // Only the overall parity bit itself flipped.
            out_status_d = ST_CORR;
            flip_s[0]    = 1'b1;
         end else if (par1_q && (syn1_q <= N_R)) begin
            out_status_d   = ST_CORR;
            flip_s[syn1_q] = 1'b1;
         end else begin
            // Even flip count with nonzero syndrome, or syndrome beyond the word.
            out_status_d = ST_UNCORR;
         end
         out_cw_d              = cw1_q ^ flip_s;
         dec_ext_s[CW_W-1:0]   = out_cw_d;
         dec_full_s            = extract_data(dec_ext_s, DATA_W);
         out_data_d            = dec_full_s[DATA_W-1:0];
      end else begin
         out_syn_d = '0;
      end
   end

   assign unused_s = ^{enc_full_s, dec_full_s};

   // Pipeline registers: both stages advance together when the output is free.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q         <= 1'b0;
         op1_q        <= 1'b0;
         data1_q      <= '0;
         cw1_q        <= '0;
         mask1_q      <= '0;
         syn1_q       <= '0;
         par1_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_op_q     <= 1'b0;
         out_data_q   <= '0;
         out_cw_q     <= '0;
         out_status_q <= ST_CLEAN;
         out_syn_q    <= '0;
      end else if (adv_s) begin
         v1_q         <= in_valid;
         op1_q        <= in_op;
         data1_q      <= in_data;
         cw1_q        <= in_cw;
         mask1_q      <= inj_mask;
         syn1_q       <= syn_s;
         par1_q       <= par_s;
         out_valid_q  <= v1_q;
         out_op_q     <= op1_q;
         out_data_q   <= out_data_d;
         out_cw_q     <= out_cw_d;
         out_status_q <= out_status_d;
         out_syn_q    <= out_syn_d;
      end
   end

   // Counter next state: clear wins, otherwise count decode events on the output handshake.
   always_comb begin
      ce_cnt_d = ce_cnt_q;
      ue_cnt_d = ue_cnt_q;
      if (cnt_clr) begin
         ce_cnt_d = '0;
         ue_cnt_d = '0;
      end else if (out_valid_q && out_ready && (out_op_q == OP_DEC)) begin
         if ((out_status_q == ST_CORR) && (ce_cnt_q != '1)) begin
            ce_cnt_d = ce_cnt_q + CNT_ONE;
         end else if ((out_status_q == ST_UNCORR) && (ue_cnt_q != '1)) begin
            ue_cnt_d = ue_cnt_q + CNT_ONE;
         end else begin
            ce_cnt_d = ce_cnt_q;
         end
      end else begin
         ce_cnt_d = ce_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ce_cnt_q <= '0;
         ue_cnt_q <= '0;
      end else begin
         ce_cnt_q <= ce_cnt_d;
         ue_cnt_q <= ue_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_op     = out_op_q;
   assign out_data   = out_data_q;
   assign out_cw     = out_cw_q;
   assign out_status = out_status_q;
   assign out_syn    = out_syn_q;
   assign ce_cnt     = ce_cnt_q;
   assign ue_cnt     = ue_cnt_q;

endmodule

// File: tb/tb_secded_codec_pipe.sv
// Directed bench for secded_codec_pipe (DATA_W=8, CNT_W=2 so saturation is reachable).
module tb_secded_codec_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_op, out_ready, cnt_clr;
   logic [7:0]  in_data;
   logic [12:0] in_cw, inj_mask;
   logic        in_ready, out_valid, out_op;
   logic [7:0]  out_data;
   logic [12:0] out_cw;
   logic [1:0]  out_status;
   logic [4:0]  out_syn;
   logic [1:0]  ce_cnt, ue_cnt;

   int          vecs = 0;
   int          fails = 0;
   int          tx, rx;
   logic        mv1, mv2, exp_adv, rdy;
   logic [7:0]  sdata [8];
   logic [12:0] cw_loop;

   always #5 clk = ~clk;

   secded_codec_pipe #(.DATA_W(8), .CNT_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_data    (in_data),
      .in_cw      (in_cw),
      .inj_mask   (inj_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op     (out_op),
      .out_data   (out_data),
      .out_cw     (out_cw),
      .out_status (out_status),
      .out_syn    (out_syn),
      .cnt_clr    (cnt_clr),
      .ce_cnt     (ce_cnt),
      .ue_cnt     (ue_cnt)
   );

   // Reference (13,8) encoder written out bit by bit.
   function automatic logic [12:0] enc8(input logic [7:0] d);
      logic c1, c2, c4, c8;
      logic [12:0] w;
      c1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      c2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      c4 = d[1] ^ d[2] ^ d[3] ^ d[7];
      c8 = d[4] ^ d[5] ^ d[6] ^ d[7];
      w  = {d[7], d[6], d[5], d[4], c8, d[3], d[2], d[1], c4, d[0], c2, c1, 1'b0};
      w[0] = ^w;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction through an idle pipe; returns with the result on out_*.
   task automatic xact(input logic op, input logic [7:0] d, input logic [12:0] cw, input logic [12:0] m);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_cw    = cw;
      inj_mask = m;
      step();
      in_valid = 1'b0;
      step();
   endtask

   task automatic check_out(input string tag, input logic op, input logic [7:0] d,
                            input logic [12:0] cw, input logic [1:0] st, input logic [4:0] syn);
      check({tag, ".valid"},  out_valid,  1'b1);
      check({tag, ".op"},     out_op,     op);
      check({tag, ".data"},   out_data,   d);
      check({tag, ".cw"},     out_cw,     cw);
      check({tag, ".status"}, out_status, st);
      check({tag, ".syn"},    out_syn,    syn);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      in_data = 8'h00; in_cw = 13'h0000; inj_mask = 13'h0000;
      sdata = '{8'hAD, 8'h00, 8'hFF, 8'h5A, 8'h01, 8'h80, 8'h3C, 8'hC3};
      step(); step();
      rst = 1'b0;
      step();

      // Reset state
      check("rst.out_valid", out_valid, 1'b0);
      check("rst.in_ready",  in_ready,  1'b1);
      check("rst.out_op",    out_op,    1'b0);
      check("rst.out_data",  out_data,  8'h00);
      check("rst.out_cw",    out_cw,    13'h0000);
      check("rst.status",    out_status, 2'b00);
      check("rst.syn",       out_syn,   5'h00);
      check("rst.ce",        ce_cnt,    2'd0);
      check("rst.ue",        ue_cnt,    2'd0);

      // Clean encode / decode
      xact(1'b0, 8'hAD, 13'h0000, 13'h0000);
      check_out("enc_ad", 1'b0, 8'hAD, 13'h14D8, 2'b00, 5'h00);
      xact(1'b1, 8'h00, 13'h14D8, 13'h0000);
      check_out("dec_clean", 1'b1, 8'hAD, 13'h14D8, 2'b00, 5'h00);

      // Injected encode, then loop the codeword back into the decoder
      xact(1'b0, 8'hAD, 13'h0000, 13'h0004);
      check_out("enc_inj", 1'b0, 8'hAD, 13'h14DC, 2'b00, 5'h00);
      cw_loop = out_cw;
      step();
      check("enc_inj.ce", ce_cnt, 2'd0);
      xact(1'b1, 8'h00, cw_loop, 13'h0000);
      check_out("dec_loop", 1'b1, 8'hAD, 13'h14D8, 2'b01, 5'h12);
      step();
      check("dec_loop.ce", ce_cnt, 2'd1);

      // Overall parity bit flipped; top Hamming position flipped
      xact(1'b1, 8'h00, 13'h14D9, 13'h0000);
      check_out("dec_bit0", 1'b1, 8'hAD, 13'h14D8, 2'b01, 5'h10);
      step();
      check("dec_bit0.ce", ce_cnt, 2'd2);
      xact(1'b1, 8'h00, 13'h04D8, 13'h0000);
      check_out("dec_bit12", 1'b1, 8'hAD, 13'h14D8, 2'b01, 5'h1C);
      step();
      check("dec_bit12.ce", ce_cnt, 2'd3);

      // Uncorrectable patterns pass the received word through
      xact(1'b1, 8'h00, 13'h14DD, 13'h0000);
      check_out("dec_dbl0", 1'b1, 8'hAD, 13'h14DD, 2'b10, 5'h02);
      step();
      check("dec_dbl0.ue", ue_cnt, 2'd1);
      xact(1'b1, 8'h00, 13'h05D8, 13'h0000);
      check_out("dec_dbl8_12", 1'b1, 8'h2D, 13'h05D8, 2'b10, 5'h04);
      step();
      check("dec_dbl8_12.ue", ue_cnt, 2'd2);
      xact(1'b1, 8'h00, 13'h15CA, 13'h0000);
      check_out("dec_syn13", 1'b1, 8'hAD, 13'h15CA, 2'b10, 5'h1D);
      step();
      check("dec_syn13.ue", ue_cnt, 2'd3);
      check("dec_syn13.ce", ce_cnt, 2'd3);

      // Saturation
      xact(1'b1, 8'h00, 13'h14D9, 13'h0000);
      step();
      check("sat.ce", ce_cnt, 2'd3);
      xact(1'b1, 8'h00, 13'h14DD, 13'h0000);
      step();
      check("sat.ue", ue_cnt, 2'd3);

      // Clear wins over a same-cycle correction
      xact(1'b1, 8'h00, 13'h14D9, 13'h0000);
      check("clr.status", out_status, 2'b01);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check("clr.ce", ce_cnt, 2'd0);
      check("clr.ue", ue_cnt, 2'd0);
      step();

      // Stream of 8 encodes with out_ready toggling
      tx = 0; rx = 0; mv1 = 1'b0; mv2 = 1'b0; rdy = 1'b1;
      for (int c = 0; c < 64 && rx < 8; c++) begin
         out_ready = rdy;
         rdy       = ~rdy;
         in_valid  = (tx < 8);
         in_op     = 1'b0;
         in_data   = sdata[(tx < 8) ? tx : 0];
         inj_mask  = 13'h0000;
         #1;
         exp_adv = !mv2 || out_ready;
         check("stream.in_ready",  in_ready,  exp_adv);
         check("stream.out_valid", out_valid, mv2);
         if (mv2) begin
            check("stream.data", out_data, sdata[rx]);
            check("stream.cw",   out_cw,   enc8(sdata[rx]));
            if (out_ready) rx++;
         end
         if (exp_adv) begin
            if (in_valid) tx++;
            mv2 = mv1;
            mv1 = in_valid;
         end
         step();
      end
      check("stream.count", rx[15:0], 16'd8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(); step();
      check("stream.drained", out_valid, 1'b0);

      // Reset with transactions in flight
      in_valid = 1'b1; in_op = 1'b0; in_data = 8'hAD; inj_mask = 13'h0000;
      step(); step();
      check("midrst.pre_valid", out_valid, 1'b1);
      rst = 1'b1; in_valid = 1'b0;
      step();
      check("midrst.out_valid", out_valid, 1'b0);
      check("midrst.out_cw",    out_cw,    13'h0000);
      rst = 1'b0;
      step();
      check("midrst.drop1", out_valid, 1'b0);
      step();
      check("midrst.drop2", out_valid, 1'b0);
      check("midrst.in_ready", in_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
